// File: rtl/alu_issue_ctrl.sv
// Issue controller for the 64-bit FP/integer ALU. It queues requests, holds operands
// stable for a per-opcode latency and returns the result with its tag.
module alu_issue_ctrl #(
    parameter int DEPTH      = 4,
    parameter int LAT_LOGIC  = 2,
    parameter int LAT_ADDSUB = 3,
    parameter int LAT_MUL    = 4,
    parameter int LAT_DIV    = 68
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [3:0]               req_op,
    input  logic [63:0]              req_a,
    input  logic [63:0]              req_b,
    input  logic [3:0]               req_tag,
    output logic [3:0]               alu_op,
    output logic [63:0]              alu_a,
    output logic [63:0]              alu_b,
    input  logic [63:0]              alu_result,
    input  logic                     alu_exc,
    input  logic                     alu_ovf,
    input  logic                     alu_unf,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [63:0]              rsp_data,
    output logic [3:0]               rsp_tag,
    output logic [2:0]               rsp_flags,
    output logic                     rsp_illegal,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    typedef struct packed {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  tag;
    } req_t;

    req_t          mem [DEPTH];
    req_t          head;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [1:0]    state;
    logic [7:0]    cnt;
    logic [7:0]    head_lat;
    logic          head_legal;
    logic          fifo_empty, push, pop;

    assign fifo_empty = (count == '0);
    // Held low while reset is asserted so every output reads 0 during reset.
    assign req_ready  = reset && (count != FULL);
    assign push       = req_valid && req_ready;
    assign pop        = !fifo_empty && (state == IDLE || (state == RESP && rsp_ready));
    assign head       = mem[rd_ptr];

    assign rsp_valid  = (state == RESP);
    assign busy       = (state != IDLE) || !fifo_empty;
    assign fifo_count = count;

    always_comb begin
        head_legal = 1'b1;
        head_lat   = 8'(LAT_LOGIC);
        case (head.op)
            4'd1, 4'd2: head_lat = 8'(LAT_ADDSUB);
            4'd3:       head_lat = 8'(LAT_MUL);
            4'd4:       head_lat = 8'(LAT_DIV);
            4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11: head_lat = 8'(LAT_LOGIC);
            default:    head_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{op: req_op, a: req_a, b: req_b, tag: req_tag};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            alu_op      <= '0;
            alu_a       <= '0;
            alu_b       <= '0;
            rsp_data    <= '0;
            rsp_tag     <= '0;
            rsp_flags   <= '0;
            rsp_illegal <= 1'b0;
        end else begin
            case (state)
                IDLE: ;
                EXEC: begin
                    // Last hold cycle: the ALU's registered output now reflects these operands.
                    if (cnt == 8'd1) begin
                        rsp_data    <= alu_result;
                        rsp_flags   <= {alu_exc, alu_ovf, alu_unf};
                        rsp_illegal <= 1'b0;
                        alu_op      <= '0;
                        state       <= RESP;
                    end
                    cnt <= cnt - 8'd1;
                end
                RESP:    if (rsp_ready && fifo_empty) state <= IDLE;
                default: state <= IDLE;
            endcase
            // Issue from IDLE or on the response handshake, giving back-to-back operation.
            if (pop) begin
                rsp_tag <= head.tag;
                if (head_legal) begin
                    alu_op <= head.op;
                    alu_a  <= head.a;
                    alu_b  <= head.b;
                    cnt    <= head_lat;
                    state  <= EXEC;
                end else begin
                    rsp_data    <= '0;
                    rsp_flags   <= '0;
                    rsp_illegal <= 1'b1;
                    state       <= RESP;
                end
            end
        end
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Upstream issue stage for the 64-bit FP/integer ALU.
- Accepts operation requests on a valid/ready interface and buffers them in a small FIFO.
- Drives one operation at a time onto the ALU's Operation/a_operand/b_operand inputs and holds them stable for a per-opcode latency.
- Captures the ALU's registered result and flags, then returns them with the request tag on a valid/ready response interface.

Parameters:
- DEPTH, 4: request FIFO entries (power of two, 2..16).
- LAT_LOGIC, 2: EXEC cycles for opcodes 5..11 (AND, OR, XOR, NOT, LS, RS, FPI).
- LAT_ADDSUB, 3: EXEC cycles for opcodes 1 and 2.
- LAT_MUL, 4: EXEC cycles for opcode 3.
- LAT_DIV, 68: EXEC cycles for opcode 4.
- All LAT_* values are in the range 2..255.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when high together with req_valid.
- req_op  in  4  ALU opcode.
- req_a  in  64  operand A.
- req_b  in  64  operand B.
- req_tag  in  4  caller ID, returned with the response.
- alu_op  out  4  drives ALU Operation.
- alu_a  out  64  drives ALU a_operand.
- alu_b  out  64  drives ALU b_operand.
- alu_result  in  64  ALU_Output.
- alu_exc  in  1  ALU Exception.
- alu_ovf  in  1  ALU Overflow.
- alu_unf  in  1  ALU Underflow.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_data  out  64  captured result.
- rsp_tag  out  4  tag of the completed request.
- rsp_flags  out  3  {exception, overflow, underflow}.
- rsp_illegal  out  1  opcode was 0 or 12..15.
- busy  out  1  state is not IDLE or FIFO is not empty.
- fifo_count  out  $clog2(DEPTH)+1  occupied FIFO entries.

Behaviour:
- Reset (reset low, asynchronous):
  - FIFO emptied; pointers and count cleared.
  - State goes to IDLE.
  - All outputs are 0, except that req_ready is 1 once reset is released.
  - Any in-flight operation is discarded and produces no response.
- FIFO:
  - req_ready = (fifo_count != DEPTH). There is no pass-through when full.
  - Push when req_valid && req_ready.
  - Pop happens only on an issue.
  - Push and pop in the same cycle leave the count unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - The request is stored as {op, a, b, tag}.
- Latency select on issue:
  - op 1..2 uses LAT_ADDSUB; op 3 uses LAT_MUL; op 4 uses LAT_DIV; op 5..11 uses LAT_LOGIC.
  - op 0 and 12..15 are illegal.
- State IDLE:
  - alu_op = 0, which gates the ALU submodules.
  - If the FIFO is not empty, pop the head.
  - Legal opcode: load alu_op/alu_a/alu_b and the tag, set cnt = LAT, go to EXEC.
  - Illegal opcode: do not drive the ALU; set rsp_data = 0, rsp_flags = 0, rsp_illegal = 1, go to RESP.
- State EXEC:
  - alu_op/alu_a/alu_b are held constant in every EXEC cycle.
  - cnt decrements each cycle.
  - In the cycle where cnt == 1:
    - sample alu_result → rsp_data;
    - sample {alu_exc, alu_ovf, alu_unf} → rsp_flags;
    - set rsp_illegal = 0;
    - go to RESP.
  - EXEC therefore lasts exactly LAT cycles. The first EXEC cycle is the first cycle the ALU sees the operands.
- State RESP:
  - alu_op = 0; rsp_valid = 1.
  - rsp_data, rsp_tag, rsp_flags and rsp_illegal are held stable until rsp_valid && rsp_ready.
  - On that handshake:
    - FIFO not empty: issue the head in the same edge (same rules as IDLE) and go to EXEC or RESP. This gives back-to-back operation with no idle cycle.
    - FIFO empty: go to IDLE and deassert rsp_valid.
  - rsp_valid is never dropped without a handshake.
- Ordering:
  - Responses return in request order; there is at most one operation in flight.
  - req_valid may rise while in EXEC or RESP; the request is queued.
- Back-pressure:
  - rsp_ready low holds RESP indefinitely. The FIFO keeps accepting until full.
- Flags:
  - Passed through unmodified. Overflow and underflow are meaningful only for op 3.
- busy:
  - busy = (state != IDLE) || (fifo_count != 0).

Test Plan:
1. Reset low mid-EXEC of a DIV, then high:
   - alu_op = 0, rsp_valid = 0, fifo_count = 0, req_ready = 1;
   - no response is produced for the aborted DIV.
2. Single AND with a = 0xFF00, b = 0x0FF0, tag 5, rsp_ready = 1:
   - alu_op = 5 for exactly 2 cycles;
   - rsp_data = 0x0F00, rsp_tag = 5, rsp_flags = 0;
   - rsp_valid is high 3 cycles after the request was accepted.
3. Five back-to-back requests with rsp_ready = 0 and DEPTH = 4:
   - the first is issued, the next 4 fill the FIFO, req_ready = 0, fifo_count = 4;
   - raising rsp_ready yields 5 responses in tag order with no IDLE cycles between them.
4. MUL of 2.0 × 3.0 (0x4000000000000000 × 0x4008000000000000):
   - alu_op = 3 held for 4 cycles;
   - rsp_data = 0x4018000000000000.
5. req_op = 13, tag 9:
   - alu_op stays 0;
   - rsp_illegal = 1, rsp_data = 0, rsp_tag = 9 on the cycle after issue.
6. Push while the FIFO holds 2 entries and an issue pops in the same cycle:
   - fifo_count remains 2;
   - the pointer wrap is correct after 3·DEPTH requests, checked by the tag sequence.
